// File: rtl/pwm_duty_ctrl.sv
// rtl/pwm_duty_ctrl.sv - front-panel duty-code controller for the PWM load input (optional slew limiter: DUTY_RAMP_EN)
module pwm_duty_ctrl #(
    parameter int DB_CYCLES   = 50000,
    parameter int RAMP_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_dn,
    input  logic       direct_mode,
    input  logic [2:0] code_in,
    output logic [2:0] load,
    output logic       step_pulse,
    output logic       sat
);

    localparam int DB_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    // Bit 0 is the up button, bit 1 the down button throughout.
    logic [1:0]      btn_s1;
    logic [1:0]      btn_s2;
    logic            mode_s1;
    logic            mode_s2;
    logic [2:0]      code_s1;
    logic [2:0]      code_s2;
    logic [2:0]      code_s3;
    logic [2:0]      code_qual;
    logic [1:0]      db_stable;
    logic [1:0]      db_stable_d;
    logic [DB_W-1:0] db_cnt [2];
    logic [1:0]      press;
    logic [2:0]      target;
    logic [2:0]      target_d;
    logic            sat_d;

    // Two-flop synchronizers for every raw front-panel input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1  <= '0;
            btn_s2  <= '0;
            mode_s1 <= 1'b0;
            mode_s2 <= 1'b0;
            code_s1 <= '0;
            code_s2 <= '0;
        end else begin
            btn_s1  <= {btn_dn, btn_up};
            btn_s2  <= btn_s1;
            mode_s1 <= direct_mode;
            mode_s2 <= mode_s1;
            code_s1 <= code_in;
            code_s2 <= code_s1;
        end
    end

    // Accept the synced code only once two consecutive samples agree, so skewed bits never leak through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_s3   <= '0;
            code_qual <= '0;
        end else begin
            code_s3 <= code_s2;
            if (code_s2 == code_s3) begin
                code_qual <= code_s2;
            end
        end
    end

    // Debounce both buttons: a new level must persist DB_CYCLES synced cycles before it is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_stable <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (btn_s2[i] != db_stable[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db_stable[i] <= btn_s2[i];
                        db_cnt[i]    <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // One-cycle press event on each rising edge of a debounced level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_stable_d <= '0;
            press       <= '0;
        end else begin
            db_stable_d <= db_stable;
            press       <= db_stable & ~db_stable_d;
        end
    end

    // Next target: direct mode tracks the qualified code, step mode applies saturating single presses.
    always_comb begin
        target_d = target;
        sat_d    = 1'b0;
        if (mode_s2) begin
            target_d = code_qual;
        end else begin
            case (press)
                2'b01: begin
                    if (target != 3'd7) begin
                        target_d = target + 3'd1;
                    end else begin
                        sat_d = 1'b1;
                    end
                end
                2'b10: begin
                    if (target != 3'd0) begin
                        target_d = target - 3'd1;
                    end else begin
                        sat_d = 1'b1;
                    end
                end
                default: begin
                    target_d = target;
                end
            endcase
        end
    end

    // Target register and saturation pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target <= '0;
            sat    <= 1'b0;
        end else begin
            target <= target_d;
            sat    <= sat_d;
        end
    end

`ifdef DUTY_RAMP_EN
    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } ramp_state_t;

    localparam int RAMP_W = (RAMP_CYCLES > 2) ? $clog2(RAMP_CYCLES) : 1;
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_CYCLES - 1);

    ramp_state_t       state;
    ramp_state_t       state_d;
    logic [RAMP_W-1:0] ramp_cnt;
    logic [RAMP_W-1:0] ramp_cnt_d;
    logic [2:0]        target_q;
    logic [2:0]        load_d;
    logic [2:0]        load_step;

    // Slew limiter: the first cycle that sees a new target counts as cycle one, so a step lands RAMP_CYCLES edges after capture.
    always_comb begin
        state_d    = state;
        ramp_cnt_d = ramp_cnt;
        load_d     = load;
        load_step  = (target > load) ? (load + 3'd1) : (load - 3'd1);
        case (state)
            IDLE: begin
                ramp_cnt_d = '0;
                if (target != load) begin
                    state_d    = RAMP;
                    ramp_cnt_d = RAMP_W'(1);
                end
            end
            RAMP: begin
                if (target == load) begin
                    state_d    = IDLE;
                    ramp_cnt_d = '0;
                end else if (target != target_q) begin
                    ramp_cnt_d = RAMP_W'(1);
                end else if (ramp_cnt == RAMP_LAST) begin
                    load_d     = load_step;
                    ramp_cnt_d = '0;
                    if (load_step == target) begin
                        state_d = IDLE;
                    end
                end else begin
                    ramp_cnt_d = ramp_cnt + 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                ramp_cnt_d = '0;
            end
        endcase
    end

    // Ramp state, counter, delayed target for change detection, and the output code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ramp_cnt   <= '0;
            target_q   <= '0;
            load       <= '0;
            step_pulse <= 1'b0;
        end else begin
            state      <= state_d;
            ramp_cnt   <= ramp_cnt_d;
            target_q   <= target;
            load       <= load_d;
            step_pulse <= (load_d != load);
        end
    end
`else
    logic unused_ramp_cfg;
    assign unused_ramp_cfg = (RAMP_CYCLES >= 2);

    // Output follows the target one cycle later; the pulse marks the first cycle of a new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load       <= '0;
            step_pulse <= 1'b0;
        end else begin
            load       <= target;
            step_pulse <= (target != load);
        end
    end
`endif

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// tb/tb_pwm_duty_ctrl.sv - directed self-checking bench for pwm_duty_ctrl (DB_CYCLES=4, RAMP_CYCLES=8)
module tb_pwm_duty_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_up;
    logic       btn_dn;
    logic       direct_mode;
    logic [2:0] code_in;
    logic [2:0] load;
    logic       step_pulse;
    logic       sat;

    int n_cmp = 0;
    int n_err = 0;
    int sat_cnt = 0;
    int pulse_cnt = 0;

    always #5 clk = ~clk;

    pwm_duty_ctrl #(
        .DB_CYCLES  (4),
        .RAMP_CYCLES(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_up     (btn_up),
        .btn_dn     (btn_dn),
        .direct_mode(direct_mode),
        .code_in    (code_in),
        .load       (load),
        .step_pulse (step_pulse),
        .sat        (sat)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
        if (sat === 1'b1) sat_cnt++;
        if (step_pulse === 1'b1) pulse_cnt++;
    endtask

    task automatic edges(input int n);
        repeat (n) edge1();
    endtask

    task automatic press(input logic up, input logic dn);
        btn_up = up;
        btn_dn = dn;
        edges(10);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        edges(10);
    endtask

    initial begin
        rst_n       = 1'b0;
        btn_up      = 1'b0;
        btn_dn      = 1'b0;
        direct_mode = 1'b0;
        code_in     = 3'd0;
        edges(3);
        chk("rst_load", 32'(load), 0);
        chk("rst_step_pulse", 32'(step_pulse), 0);
        chk("rst_sat", 32'(sat), 0);
        rst_n = 1'b1;
        edges(5);

`ifndef DUTY_RAMP_EN
        sat_cnt   = 0;
        pulse_cnt = 0;
        btn_up = 1'b1;
        edges(8);
        chk("press1_before_latency", 32'(load), 0);
        edge1();
        chk("press1_load_at_e0_plus_8", 32'(load), 1);
        chk("press1_step_pulse", 32'(step_pulse), 1);
        edge1();
        chk("step_pulse_one_cycle", 32'(step_pulse), 0);
        edges(8);
        btn_up = 1'b0;
        edges(10);
        for (int i = 2; i <= 7; i++) begin
            press(1'b1, 1'b0);
            chk("step_up_load", 32'(load), i);
        end
        chk("no_sat_below_7", 32'(sat_cnt), 0);
        chk("pulses_1_to_7", 32'(pulse_cnt), 7);
        sat_cnt = 0;
        press(1'b1, 1'b0);
        chk("sat_up_count", 32'(sat_cnt), 1);
        chk("sat_up_load", 32'(load), 7);
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        chk("step_down_to_5", 32'(load), 5);

        btn_up = 1'b1;
        edges(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_load", 32'(load), 0);
        chk("async_rst_step_pulse", 32'(step_pulse), 0);
        chk("async_rst_sat", 32'(sat), 0);
        btn_up = 1'b0;
        edges(2);
        rst_n = 1'b1;
        edges(20);
        chk("post_rst_idle_load", 32'(load), 0);

        sat_cnt = 0;
        press(1'b0, 1'b1);
        chk("sat_down_count", 32'(sat_cnt), 1);
        chk("sat_down_load", 32'(load), 0);
        for (int i = 1; i <= 3; i++) begin
            press(1'b1, 1'b0);
        end
        chk("climb_to_3", 32'(load), 3);
        sat_cnt   = 0;
        pulse_cnt = 0;
        btn_up = 1'b1;
        edges(3);
        btn_up = 1'b0;
        edges(15);
        chk("glitch_load", 32'(load), 3);
        chk("glitch_pulses", 32'(pulse_cnt), 0);
        press(1'b1, 1'b1);
        chk("both_load", 32'(load), 3);
        chk("both_sat", 32'(sat_cnt), 0);

        code_in = 3'd3;
        edges(5);
        direct_mode = 1'b1;
        edges(10);
        chk("direct_enter_load", 32'(load), 3);
        pulse_cnt = 0;
        code_in = 3'd6;
        edges(5);
        chk("direct_before_latency", 32'(load), 3);
        edge1();
        chk("direct_load_at_e0_plus_5", 32'(load), 6);
        chk("direct_step_pulse", 32'(step_pulse), 1);
        edges(10);
        chk("direct_single_pulse", 32'(pulse_cnt), 1);
        sat_cnt = 0;
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        chk("direct_ignores_buttons", 32'(load), 6);
        chk("direct_no_sat", 32'(sat_cnt), 0);
`else
        direct_mode = 1'b1;
        code_in     = 3'd0;
        edges(10);
        pulse_cnt = 0;
        code_in = 3'd4;
        edges(12);
        chk("ramp_before_first_step", 32'(load), 0);
        edge1();
        chk("ramp_step1_load", 32'(load), 1);
        chk("ramp_step1_pulse", 32'(step_pulse), 1);
        edges(7);
        chk("ramp_hold_1", 32'(load), 1);
        edge1();
        chk("ramp_step2_load", 32'(load), 2);
        edges(8);
        chk("ramp_step3_load", 32'(load), 3);
        edges(8);
        chk("ramp_step4_load", 32'(load), 4);
        edges(10);
        chk("ramp_final_load", 32'(load), 4);
        chk("ramp_pulse_count", 32'(pulse_cnt), 4);

        code_in = 3'd1;
        edges(13);
        chk("ramp_down_to_3", 32'(load), 3);
        code_in = 3'd2;
        edges(12);
        chk("retarget_restart_hold", 32'(load), 3);
        edge1();
        chk("retarget_step_load", 32'(load), 2);
        chk("retarget_step_pulse", 32'(step_pulse), 1);
        edges(20);
        chk("retarget_settled", 32'(load), 2);

        code_in = 3'd4;
        edges(14);
        chk("midramp_load", 32'(load), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midramp_rst_load", 32'(load), 0);
        chk("midramp_rst_step_pulse", 32'(step_pulse), 0);
        edges(3);
        rst_n = 1'b1;
        edges(12);
        chk("post_rst_ramp_hold", 32'(load), 0);
        edge1();
        chk("post_rst_ramp_step1", 32'(load), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_duty_ctrl.md
# pwm_duty_ctrl

Upstream duty-cycle controller for the PWM generator. Conditions asynchronous front-panel inputs: two raw push buttons and a 3-bit direct code. It produces the registered 3-bit duty code that drives the PWM `load` input. Buttons step the duty up or down with saturation; direct mode tracks the input code. An optional compile-time slew limiter ramps the output toward the target.

## Interface
- `DB_CYCLES`, 50000: consecutive stable synchronized cycles required to accept a button level change (≥2).
- `RAMP_CYCLES`, 1024: cycles between output steps when ramping (≥2; used only with `DUTY_RAMP_EN`).
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_up`  in  1  raw, asynchronous increment button; active high.
- `btn_dn`  in  1  raw, asynchronous decrement button; active high.
- `direct_mode`  in  1  raw level. 1 = target follows `code_in`; 0 = button step mode.
- `code_in`  in  3  raw direct duty code.
- `load`  out  3  duty code to the PWM `load` input.
- `step_pulse`  out  1  one-cycle pulse on every cycle in which `load` changes value.
- `sat`  out  1  one-cycle pulse when an accepted press is rejected because the target is already at 7 (up) or 0 (down).

## Operation
- **Synchronizers.** Every raw input passes through a 2-flop synchronizer. Reset value is 0.
- **`code_in` qualification.** A `code_qual` register loads the synced code only when two consecutive synced samples are equal.
- **Debouncer (one per button).**
  - Keeps `stable` (reset 0) and a counter (reset 0).
  - When the synced value differs from `stable`, the counter increments.
  - At a mismatch edge where the counter is at `DB_CYCLES-1`, `stable` takes the synced value and the counter clears.
  - Any cycle where the synced value matches `stable` clears the counter.
- **Press event.** A registered one-cycle pulse on each 0→1 transition of `stable`.
- **Target register** (3 bits, reset 0):
  - Step mode, up press only: target +1 if below 7; otherwise unchanged and `sat` pulses.
  - Step mode, down press only: target −1 if above 0; otherwise unchanged and `sat` pulses.
  - Up and down press events in the same cycle: no change, no `sat`.
  - Direct mode: target = `code_qual` every cycle. Press events are ignored and `sat` stays 0. Debouncers keep running.
  - Mode switch: the first cycle in the new mode applies that mode's rule. There is no handshake.
- **Output path, without ramp.** `load` = target, registered one cycle later.
- **Output path, with ramp.** Two-state machine:
  - IDLE (`load` == target): ramp counter held at 0.
  - RAMP (`load` != target): ramp counter counts. At the edge where it equals `RAMP_CYCLES-1`, `load` moves 1 toward the target and the counter clears.
  - Any target change while in RAMP clears the ramp counter.
  - Returns to IDLE when `load` == target.
- **Wrap-around.** Never. All arithmetic saturates within 0..7.

## Timing
- Reset (asynchronous, any time, including mid-debounce or mid-ramp): `load`=0, `step_pulse`=0, `sat`=0. All synchronizers, counters, target and FSM return to 0/IDLE. Operation resumes on the first edge after `rst_n` deasserts.
- **Button latency.** Let E0 be the first edge that samples the raw button high, with the raw level held high throughout.
  - `stable` flips at E0+1+`DB_CYCLES`.
  - Press event at E0+2+`DB_CYCLES`.
  - Target updates at E0+3+`DB_CYCLES`.
  - `load` updates at E0+4+`DB_CYCLES` (no ramp).
- A glitch shorter than `DB_CYCLES` synchronized cycles produces no event.
- **Direct-mode latency.** A `code_in` change held steady reaches `load` at E0+5 (2 sync, 1 qualify, 1 target, 1 load).
- `step_pulse` is high in the same cycle in which the new `load` value is first visible.
- **Ramp timing.** The first step occurs `RAMP_CYCLES` edges after the target is captured. Each following step comes `RAMP_CYCLES` edges later.

## Configuration
- `DUTY_RAMP_EN` defined: the slew-limiting FSM and ramp counter are built. `load` moves at most 1 code per `RAMP_CYCLES` cycles.
- `DUTY_RAMP_EN` not defined: there is no ramp logic, `load` follows the target with a 1-cycle delay, and `RAMP_CYCLES` is unused.

## Test plan
All scenarios use `DB_CYCLES`=4 and `RAMP_CYCLES`=8.

1. **Reset.** Assert `rst_n`=0 mid-run with `load`=5 → `load`=0, `step_pulse`=0 and `sat`=0 immediately, without waiting for a clock edge. `load` stays 0 after release with no input.
2. **Step and saturate.** Step mode, no ramp. Press `btn_up` 8 times, each held 10 cycles → `load` goes 1..7. The first `load` change is exactly 8 edges after E0. The 8th press pulses `sat` once and `load` stays 7.
3. **Glitch rejection and simultaneous press.** A 3-cycle `btn_up` pulse → no change. `btn_up` and `btn_dn` rising together from `load`=3 → `load` stays 3 and `sat`=0.
4. **Direct mode.** Set `direct_mode`=1 and `code_in`=6 → `load`=6 at E0+5 with one `step_pulse`. Button presses while in direct mode → no change.
5. **Ramp.** With `DUTY_RAMP_EN` defined, direct mode, step `code_in` 0→4 → `load` reaches 1, 2, 3, 4 at 8-cycle intervals, with 4 `step_pulse` pulses. Changing `code_in` to 2 while `load`=3 → the ramp counter restarts and `load` steps down to 2 eight edges after the new target is captured.
6. **Reset mid-ramp.** Assert reset mid-ramp → `load`=0 and the FSM is IDLE. After release with direct code 4, the ramp restarts from 0.
